// File: rtl/axi_lite_slave_front_if.sv
// AXI4-Lite channel bundle between an AXI master and the bridge front end.
// Carries no logic. Latency and backpressure belong to the endpoints.
// Uses standard AXI valid/ready on AW, W, B, AR and R.
interface axi_lite_slave_front_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic                  awvalid;
    logic                  awready;
    logic [ADDR_W-1:0]     awaddr;
    logic                  wvalid;
    logic                  wready;
    logic [DATA_W-1:0]     wdata;
    logic [DATA_W/8-1:0]   wstrb;
    logic                  bvalid;
    logic                  bready;
    logic [1:0]            bresp;
    logic                  arvalid;
    logic                  arready;
    logic [ADDR_W-1:0]     araddr;
    logic                  rvalid;
    logic                  rready;
    logic [DATA_W-1:0]     rdata;
    logic [1:0]            rresp;

    modport master (
        output awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
        input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );

    modport slave (
        input  awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
        output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );
endinterface

// File: rtl/axi_lite_slave_front.sv
// AXI4-Lite slave front end: packs AW/W/AR into command words and returns the FIFO responses on B/R.
// Latency: handshake N, push N+1, response pop M>=N+2, B/R valid M+1. One transaction is outstanding at a time.
// Backpressure: a full command FIFO stalls in PUSH, an empty response FIFO stalls in WAIT_RSP, and new requests wait for IDLE.
module axi_lite_slave_front #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int CMD_W  = 1 + ADDR_W + DATA_W/8 + DATA_W,
    parameter int RSP_W  = 2 + DATA_W
) (
    input  logic                 wclk,
    input  logic                 wrst_n,
    axi_lite_slave_front_if.slave axi,
    output logic                 cmd_winc,
    output logic [CMD_W-1:0]     cmd_wdata,
    input  logic                 cmd_wfull,
    output logic                 rsp_rinc,
    input  logic [RSP_W-1:0]     rsp_rdata,
    input  logic                 rsp_rempty
);
    localparam int STRB_W = DATA_W / 8;

    typedef enum logic [2:0] {IDLE, PUSH, WAIT_RSP, B_RESP, R_RESP} state_t;

    state_t              state_q, state_d;
    logic                rd_prio_q;
    logic                pend_wr_q;
    logic [CMD_W-1:0]    cmd_q;
    logic [1:0]          resp_q;
    logic [DATA_W-1:0]   data_q;

    logic                wr_elig, rd_elig;
    logic                grant_wr, grant_rd;
    logic                winc, rinc;

    assign wr_elig = axi.awvalid && axi.wvalid;
    assign rd_elig = axi.arvalid;

    always_comb begin
        state_d  = state_q;
        grant_wr = 1'b0;
        grant_rd = 1'b0;
        winc     = 1'b0;
        rinc     = 1'b0;
        case (state_q)
            IDLE: begin
                // rd_prio alternates the winner only when both sides compete
                if (wr_elig && !(rd_elig && rd_prio_q)) begin
                    grant_wr = 1'b1;
                    state_d  = PUSH;
                end else if (rd_elig) begin
                    grant_rd = 1'b1;
                    state_d  = PUSH;
                end
            end
            PUSH: begin
                winc = !cmd_wfull;
                if (!cmd_wfull) state_d = WAIT_RSP;
            end
            WAIT_RSP: begin
                rinc = !rsp_rempty;
                if (!rsp_rempty) state_d = pend_wr_q ? B_RESP : R_RESP;
            end
            B_RESP: if (axi.bready) state_d = IDLE;
            R_RESP: if (axi.rready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            state_q   <= IDLE;
            rd_prio_q <= 1'b0;
            pend_wr_q <= 1'b0;
            cmd_q     <= '0;
            resp_q    <= 2'b00;
            data_q    <= '0;
        end else begin
            state_q <= state_d;
            if (grant_wr) begin
                cmd_q     <= {1'b1, axi.awaddr, axi.wstrb, axi.wdata};
                pend_wr_q <= 1'b1;
                rd_prio_q <= 1'b1;
            end else if (grant_rd) begin
                cmd_q     <= {1'b0, axi.araddr, {STRB_W{1'b0}}, {DATA_W{1'b0}}};
                pend_wr_q <= 1'b0;
                rd_prio_q <= 1'b0;
            end
            if (rinc) begin
                resp_q <= rsp_rdata[RSP_W-1 -: 2];
                // write responses carry no meaningful data, so rdata keeps the last read value
                if (!pend_wr_q) data_q <= rsp_rdata[DATA_W-1:0];
            end
        end
    end

    assign axi.awready = grant_wr;
    assign axi.wready  = grant_wr;
    assign axi.arready = grant_rd;
    assign axi.bvalid  = (state_q == B_RESP);
    assign axi.bresp   = resp_q;
    assign axi.rvalid  = (state_q == R_RESP);
    assign axi.rresp   = resp_q;
    assign axi.rdata   = data_q;
    assign cmd_winc    = winc;
    assign cmd_wdata   = cmd_q;
    assign rsp_rinc    = rinc;
endmodule

// File: tb/tb_axi_lite_slave_front.sv
// Bench for axi_lite_slave_front: directed scenarios, then randomized transactions.
// It plays both the AXI master and the two FIFO endpoints.
module tb_axi_lite_slave_front;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int CMD_W  = 1 + ADDR_W + DATA_W/8 + DATA_W;
    localparam int RSP_W  = 2 + DATA_W;

    logic             wclk;
    logic             wrst_n;
    logic             cmd_winc;
    logic [CMD_W-1:0] cmd_wdata;
    logic             cmd_wfull;
    logic             rsp_rinc;
    logic [RSP_W-1:0] rsp_rdata;
    logic             rsp_rempty;

    axi_lite_slave_front_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) axi ();

    axi_lite_slave_front #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .wclk       (wclk),
        .wrst_n     (wrst_n),
        .axi        (axi),
        .cmd_winc   (cmd_winc),
        .cmd_wdata  (cmd_wdata),
        .cmd_wfull  (cmd_wfull),
        .rsp_rinc   (rsp_rinc),
        .rsp_rdata  (rsp_rdata),
        .rsp_rempty (rsp_rempty)
    );

    initial wclk = 1'b0;
    always #5 wclk = ~wclk;

    int n_pass  = 0;
    int n_total = 0;
    bit rd_prio_m = 1'b0;   // reference arbitration memory: 1 after a write grant

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge wclk);
        #1;
    endtask

    // One complete transaction from the master's point of view, with the chosen
    // stall counts on each stage. The expected winner comes from the arbitration rule.
    task automatic do_txn(input bit pw, input bit pr,
                          input logic [31:0] waddr, input logic [31:0] wdat, input logic [3:0] strb,
                          input logic [31:0] raddr, input int nsplit, input int nfull,
                          input int nempty, input int nready,
                          input logic [1:0] rsp, input logic [31:0] rdat);
        bit               exp_wr;
        bit               exp_rd;
        logic [CMD_W-1:0] exp_cmd;
        axi.awaddr = waddr;
        axi.wdata  = wdat;
        axi.wstrb  = strb;
        axi.araddr = raddr;
        for (int i = 0; i < nsplit; i++) begin
            axi.awvalid = 1'b1;
            #1;
            chk("split_awready", axi.awready, 0);
            chk("split_wready", axi.wready, 0);
            tick();
        end
        axi.awvalid = pw;
        axi.wvalid  = pw;
        axi.arvalid = pr;
        #1;
        exp_wr = pw && !(pr && rd_prio_m);
        exp_rd = pr && !exp_wr;
        chk("grant_awready", axi.awready, exp_wr);
        chk("grant_wready", axi.wready, exp_wr);
        chk("grant_arready", axi.arready, exp_rd);
        rd_prio_m = exp_wr;
        exp_cmd = exp_wr ? {1'b1, waddr, strb, wdat} : {1'b0, raddr, 4'h0, 32'h0};
        tick();
        axi.awvalid = 1'b0;
        axi.wvalid  = 1'b0;
        axi.arvalid = 1'b0;
        for (int i = 0; i < nfull; i++) begin
            cmd_wfull = 1'b1;
            #1;
            chk("full_no_winc", cmd_winc, 0);
            tick();
        end
        cmd_wfull = 1'b0;
        #1;
        chk("push_winc", cmd_winc, 1);
        chk("push_cmd", cmd_wdata, exp_cmd);
        chk("push_no_rinc", rsp_rinc, 0);
        tick();
        chk("after_push_winc", cmd_winc, 0);
        for (int i = 0; i < nempty; i++) begin
            rsp_rempty = 1'b1;
            #1;
            chk("empty_no_rinc", rsp_rinc, 0);
            tick();
        end
        rsp_rempty = 1'b0;
        rsp_rdata  = {rsp, rdat};
        #1;
        chk("pop_rinc", rsp_rinc, 1);
        chk("pop_no_bvalid", axi.bvalid, 0);
        chk("pop_no_rvalid", axi.rvalid, 0);
        tick();
        rsp_rempty = 1'b1;
        rsp_rdata  = {$urandom_range(0, 3), $urandom()};
        for (int i = 0; i < nready; i++) begin
            axi.arvalid = 1'b1;
            axi.awvalid = 1'b1;
            axi.wvalid  = 1'b1;
            #1;
            chk("hold_valid", exp_wr ? axi.bvalid : axi.rvalid, 1);
            chk("hold_resp", exp_wr ? axi.bresp : axi.rresp, rsp);
            chk("busy_arready", axi.arready, 0);
            chk("busy_awready", axi.awready, 0);
            chk("busy_rinc", rsp_rinc, 0);
            tick();
        end
        axi.arvalid = 1'b0;
        axi.awvalid = 1'b0;
        axi.wvalid  = 1'b0;
        axi.bready  = exp_wr;
        axi.rready  = !exp_wr;
        #1;
        if (exp_wr) begin
            chk("b_valid", axi.bvalid, 1);
            chk("b_resp", axi.bresp, rsp);
            chk("b_no_rvalid", axi.rvalid, 0);
        end else begin
            chk("r_valid", axi.rvalid, 1);
            chk("r_resp", axi.rresp, rsp);
            chk("r_data", axi.rdata, rdat);
            chk("r_no_bvalid", axi.bvalid, 0);
        end
        tick();
        axi.bready = 1'b0;
        axi.rready = 1'b0;
        #1;
        chk("done_bvalid", axi.bvalid, 0);
        chk("done_rvalid", axi.rvalid, 0);
    endtask

    initial begin
        wrst_n      = 1'b0;
        axi.awvalid = 1'b0;
        axi.awaddr  = '0;
        axi.wvalid  = 1'b0;
        axi.wdata   = '0;
        axi.wstrb   = '0;
        axi.bready  = 1'b0;
        axi.arvalid = 1'b0;
        axi.araddr  = '0;
        axi.rready  = 1'b0;
        cmd_wfull   = 1'b0;
        rsp_rempty  = 1'b1;
        rsp_rdata   = '0;
        #2;
        chk("rst_awready", axi.awready, 0);
        chk("rst_arready", axi.arready, 0);
        chk("rst_bvalid", axi.bvalid, 0);
        chk("rst_rvalid", axi.rvalid, 0);
        chk("rst_winc", cmd_winc, 0);
        chk("rst_cmd", cmd_wdata, 0);
        chk("rst_rinc", rsp_rinc, 0);
        chk("rst_rdata", axi.rdata, 0);
        tick();
        tick();
        wrst_n = 1'b1;
        tick();

        // contention: write wins first, then read, then write again
        do_txn(1, 1, 32'h100, 32'hA5A5_0001, 4'h3, 32'h200, 0, 0, 0, 0, 2'b00, 32'h0);
        do_txn(0, 1, 32'h0, 32'h0, 4'h0, 32'h200, 0, 0, 0, 0, 2'b00, 32'hCAFE_0002);
        do_txn(1, 1, 32'h104, 32'hA5A5_0003, 4'hC, 32'h204, 0, 0, 0, 0, 2'b01, 32'h0);
        do_txn(0, 1, 32'h0, 32'h0, 4'h0, 32'h204, 0, 0, 0, 0, 2'b00, 32'hCAFE_0004);
        // single write and single read
        do_txn(1, 0, 32'h10, 32'hDEAD_BEEF, 4'hF, 32'h0, 0, 0, 0, 0, 2'b00, 32'h1357_9BDF);
        do_txn(0, 1, 32'h0, 32'h0, 4'h0, 32'h20, 0, 0, 0, 0, 2'b10, 32'h1234_5678);
        // command FIFO full for 5 cycles, bready withheld for 4 with AR pending
        do_txn(1, 0, 32'h30, 32'h0BAD_F00D, 4'h5, 32'h0, 0, 5, 0, 4, 2'b11, 32'h0);
        do_txn(0, 1, 32'h0, 32'h0, 4'h0, 32'h34, 0, 0, 3, 2, 2'b00, 32'h8765_4321);
        // AW alone for 3 cycles before W arrives
        do_txn(1, 0, 32'h40, 32'h5555_AAAA, 4'h9, 32'h0, 3, 0, 0, 0, 2'b00, 32'h0);

        // reset while waiting for a response
        axi.araddr  = 32'h50;
        axi.arvalid = 1'b1;
        #1;
        chk("rstmid_arready", axi.arready, 1);
        tick();
        axi.arvalid = 1'b0;
        tick();
        #1;
        chk("rstmid_wait_rinc", rsp_rinc, 0);
        rsp_rempty = 1'b0;
        rsp_rdata  = {2'b01, 32'hFFFF_0000};
        wrst_n     = 1'b0;
        #1;
        chk("rstmid_rinc", rsp_rinc, 0);
        chk("rstmid_cmd", cmd_wdata, 0);
        chk("rstmid_rdata", axi.rdata, 0);
        chk("rstmid_rresp", axi.rresp, 0);
        chk("rstmid_bresp", axi.bresp, 0);
        chk("rstmid_rvalid", axi.rvalid, 0);
        chk("rstmid_winc", cmd_winc, 0);
        tick();
        rsp_rempty = 1'b1;
        wrst_n     = 1'b1;
        rd_prio_m  = 1'b0;
        tick();
        do_txn(0, 1, 32'h0, 32'h0, 4'h0, 32'h60, 0, 0, 1, 0, 2'b00, 32'h0246_8ACE);

        for (int t = 0; t < 40; t++) begin
            int  sel;
            bit  pw;
            bit  pr;
            sel = $urandom_range(0, 2);
            pw  = (sel != 1);
            pr  = (sel != 0);
            do_txn(pw, pr, $urandom(), $urandom(), 4'($urandom_range(0, 15)), $urandom(),
                   pw ? $urandom_range(0, 2) : 0, $urandom_range(0, 3),
                   $urandom_range(0, 3), $urandom_range(0, 2),
                   2'($urandom_range(0, 3)), $urandom());
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
